mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencer between the EX stage and the pipelined 4-2-compressor multiplier array.
- Accepts one RISC-V M-extension multiply request at a time.
- Drives signed/unsigned operand controls into the array and counts the fixed array latency.
- Selects the low or high product half and holds the result until EX takes it.
- Keeps a one-entry product cache so an adjacent MULH[S][U]/MUL pair on identical operands completes without re-running the array.

Parameters:
- LATENCY, 4, cycles from the MulStart cycle to MulProduct valid; legal 1..15.
- XLEN, 64, operand width; product is 2*XLEN.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-low
- ReqValid  in  1  EX presents a request
- ReqReady  out  1  controller accepts a request this cycle
- ReqOp  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5..7 reserved
- ReqRs1  in  XLEN  multiplicand
- ReqRs2  in  XLEN  multiplier
- ReqRd  in  5  destination tag, returned unchanged
- Flush  in  1  abort the in-flight or pending operation
- MulStart  out  1  one-cycle launch pulse to the array
- MulA  out  XLEN  array operand A
- MulB  out  XLEN  array operand B
- MulSignA  out  1  treat MulA as signed
- MulSignB  out  1  treat MulB as signed
- MulProduct  in  2*XLEN  array result
- RespValid  out  1  result available
- RespReady  in  1  EX consumes the result
- RespData  out  XLEN  selected result
- RespRd  out  5  tag of the result
- Busy  out  1  high in any state except IDLE; drives the EX hold

Behaviour:
- Reset (Rst=0 at posedge):
  - state=IDLE, ReqReady=1, RespValid=0, MulStart=0, Busy=0.
  - MulA/MulB/RespData=0, MulSignA/B=0, RespRd=0.
  - Latency counter=0; cache valid bit=0.
  - Reset mid-operation discards everything; a later MulProduct is ignored.
- States: IDLE, LAUNCH, WAIT, DONE.
- Handshake: a request is accepted when ReqValid && ReqReady. ReqReady = (state==IDLE) && !Flush.
- Signedness per op:
  - MUL: (1,1).
  - MULH: (1,1).
  - MULHSU: (1,0).
  - MULHU: (0,0).
  - MULW: (1,1), with operands sext(Rs1[31:0]) and sext(Rs2[31:0]).
- Result selection:
  - MUL: P[63:0].
  - MULH/MULHSU/MULHU: P[127:64].
  - MULW: sext(P[31:0]).
- Cache: holds {A, B, SignA, SignB, P[127:0]} plus a valid bit. It is written at the WAIT completion for every op except MULW.
- Hit rules:
  - MUL hits when Rs1/Rs2 match the cached operands, regardless of the cached signs.
  - MULH/MULHSU/MULHU hit only when operands and signs match exactly.
  - MULW never hits.
- IDLE, accepted request:
  - Hit: go to DONE with RespData/RespRd loaded. RespValid=1 in the following cycle (latency 1).
  - Miss: latch the operands and signs, go to LAUNCH.
- LATENCY handling:
  - LAUNCH: MulStart=1 for exactly one cycle, counter loaded with LATENCY, go to WAIT.
  - WAIT: counter decrements each cycle. When the counter reaches 0, MulProduct is sampled, the result is selected, the cache is updated, and the state goes to DONE.
  - Miss latency: accept at cycle t gives MulStart at t+1, sampling at t+1+LATENCY, and RespValid at t+2+LATENCY.
- DONE: RespValid=1, RespData and RespRd stable. On RespReady go to IDLE; the next request can be accepted in the cycle after the handshake (no same-cycle bypass).
- Flush:
  - In LAUNCH or WAIT: go to IDLE next cycle, no response, cache unchanged. A MulStart already issued stays issued, and its product is ignored.
  - In DONE: RespValid drops next cycle and the state goes to IDLE.
  - Flush wins over RespReady in the same cycle.
  - In IDLE it blocks acceptance.
- Reserved ReqOp values: accepted and completed with RespData=0 after 1 cycle via DONE; no array launch; cache untouched.
- RespValid never deasserts without RespReady or Flush.

Decomposition:
- Shared package/defines: op encodings (MUL_OP_*), XLEN, state encodings, default LATENCY.
- Natural sub-module: mul_prod_cache. It holds the registered cache entry, the hit-compare logic and the half/sext selection. The FSM and counter stay in the top.

Test Plan:
- Rst low for 2 cycles while MulProduct toggles -> RespValid=0, ReqReady=1, MulStart=0, cache invalid.
- MULHU Rs1=0xFFFF_FFFF_FFFF_FFFF, Rs2=2 at cycle t, LATENCY=4, model array -> MulStart at t+1 only, RespValid at t+6, RespData=1, RespRd echoed.
- MULH Rs1=-3, Rs2=5, then immediately MUL with the same operands -> second response RespValid one cycle after accept, RespData=0xFFFF_FFFF_FFFF_FFF1, no second MulStart. Also MULHU on the same operands after MULH -> miss, MulStart issued.
- MULW Rs1=0x0000_0001_8000_0000, Rs2=2 -> RespData=0x0000_0000_0000_0000. Second case: MULW Rs1=0x4000_0000, Rs2=2 -> RespData=0xFFFF_FFFF_8000_0000.
- Flush asserted 2 cycles into WAIT -> no RespValid, Busy low next cycle. The late MulProduct is ignored and a following request starts a fresh MulStart. Cache is unchanged: a MUL on the prior operands still hits.
- RespReady held low 10 cycles in DONE -> RespData/RespRd stable, ReqReady=0 throughout. Then RespReady and Flush asserted together -> flush wins, no double handshake.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared encodings and defaults for the M-extension multiply sequencer.
package mul_seq_ctrl_pkg;

    localparam int unsigned MUL_XLEN        = 64;
    localparam int unsigned MUL_LATENCY_DEF = 4;
    localparam int unsigned MUL_CNT_W       = 4;

    localparam logic [2:0] MUL_OP_MUL    = 3'd0;
    localparam logic [2:0] MUL_OP_MULH   = 3'd1;
    localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
    localparam logic [2:0] MUL_OP_MULW   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } mul_state_e;

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op > MUL_OP_MULW;
    endfunction

    function automatic logic op_sign_a(input logic [2:0] op);
        return op != MUL_OP_MULHU;
    endfunction

    function automatic logic op_sign_b(input logic [2:0] op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH) || (op == MUL_OP_MULW);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_cache.sv
// One-entry product cache: registered entry, hit compare, and low/high/word result selection.
module mul_prod_cache
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = MUL_XLEN
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              fill_en,
    input  logic [2:0]        fill_op,
    input  logic [XLEN-1:0]   fill_a,
    input  logic [XLEN-1:0]   fill_b,
    input  logic              fill_sign_a,
    input  logic              fill_sign_b,
    input  logic [2*XLEN-1:0] fill_product,
    output logic [XLEN-1:0]   fill_data,
    input  logic [2:0]        lk_op,
    input  logic [XLEN-1:0]   lk_a,
    input  logic [XLEN-1:0]   lk_b,
    input  logic              lk_sign_a,
    input  logic              lk_sign_b,
    output logic              lk_hit,
    output logic [XLEN-1:0]   lk_data
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              opnd_match;
    logic              sign_match;

    function automatic logic [XLEN-1:0] select_half(input logic [2:0] op,
                                                    input logic [2*XLEN-1:0] p);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            MUL_OP_MUL:                               r = p[XLEN-1:0];
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: r = p[2*XLEN-1:XLEN];
            MUL_OP_MULW:                              r = {{(XLEN-32){p[31]}}, p[31:0]};
            default:                                  r = '0;
        endcase
        return r;
    endfunction

    // Word results never enter the cache, so a later MUL cannot see a truncated product.
    always_comb begin
        valid_d  = valid_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        prod_d   = prod_q;
        if (fill_en && (fill_op != MUL_OP_MULW)) begin
            valid_d  = 1'b1;
            a_d      = fill_a;
            b_d      = fill_b;
            sign_a_d = fill_sign_a;
            sign_b_d = fill_sign_b;
            prod_d   = fill_product;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            prod_q   <= prod_d;
        end
    end

    // The low half is sign-agnostic, so MUL only needs the operands to match.
    always_comb begin
        opnd_match = valid_q && (lk_a == a_q) && (lk_b == b_q);
        sign_match = (lk_sign_a == sign_a_q) && (lk_sign_b == sign_b_q);
        lk_hit     = 1'b0;
        case (lk_op)
            MUL_OP_MUL:                               lk_hit = opnd_match;
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: lk_hit = opnd_match && sign_match;
            default:                                  lk_hit = 1'b0;
        endcase
    end

    assign lk_data   = select_half(lk_op, prod_q);
    assign fill_data = select_half(fill_op, fill_product);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer between EX and the pipelined multiplier array: launch, latency count, result hold.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = MUL_LATENCY_DEF,
    parameter int unsigned XLEN    = MUL_XLEN
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [2:0]        ReqOp,
    input  logic [XLEN-1:0]   ReqRs1,
    input  logic [XLEN-1:0]   ReqRs2,
    input  logic [4:0]        ReqRd,
    input  logic              Flush,
    output logic              MulStart,
    output logic [XLEN-1:0]   MulA,
    output logic [XLEN-1:0]   MulB,
    output logic              MulSignA,
    output logic              MulSignB,
    input  logic [2*XLEN-1:0] MulProduct,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [XLEN-1:0]   RespData,
    output logic [4:0]        RespRd,
    output logic              Busy
);

    localparam logic [MUL_CNT_W-1:0] CNT_LOAD = MUL_CNT_W'(LATENCY);
    localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);

    mul_state_e           state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      a_q, a_d;
    logic [XLEN-1:0]      b_q, b_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [2:0]           op_q, op_d;
    logic [4:0]           rd_q, rd_d;
    logic [XLEN-1:0]      resp_data_q, resp_data_d;

    logic                 req_is_w;
    logic [XLEN-1:0]      req_a;
    logic [XLEN-1:0]      req_b;
    logic                 req_sign_a;
    logic                 req_sign_b;
    logic                 sample;
    logic                 lk_hit;
    logic [XLEN-1:0]      lk_data;
    logic [XLEN-1:0]      fill_data;

    always_comb begin
        req_is_w   = (ReqOp == MUL_OP_MULW);
        req_a      = req_is_w ? {{(XLEN-32){ReqRs1[31]}}, ReqRs1[31:0]} : ReqRs1;
        req_b      = req_is_w ? {{(XLEN-32){ReqRs2[31]}}, ReqRs2[31:0]} : ReqRs2;
        req_sign_a = op_sign_a(ReqOp);
        req_sign_b = op_sign_b(ReqOp);
    end

    mul_prod_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .Clk          (Clk),
        .Rst          (Rst),
        .fill_en      (sample),
        .fill_op      (op_q),
        .fill_a       (a_q),
        .fill_b       (b_q),
        .fill_sign_a  (sign_a_q),
        .fill_sign_b  (sign_b_q),
        .fill_product (MulProduct),
        .fill_data    (fill_data),
        .lk_op        (ReqOp),
        .lk_a         (req_a),
        .lk_b         (req_b),
        .lk_sign_a    (req_sign_a),
        .lk_sign_b    (req_sign_b),
        .lk_hit       (lk_hit),
        .lk_data      (lk_data)
    );

    assign ReqReady = (state_q == ST_IDLE) && !Flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        op_d        = op_q;
        rd_d        = rd_q;
        resp_data_d = resp_data_q;
        sample      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid && ReqReady) begin
                    rd_d = ReqRd;
                    if (op_is_reserved(ReqOp)) begin
                        resp_data_d = '0;
                        state_d     = ST_DONE;
                    end else if (lk_hit) begin
                        resp_data_d = lk_data;
                        state_d     = ST_DONE;
                    end else begin
                        a_d      = req_a;
                        b_d      = req_b;
                        sign_a_d = req_sign_a;
                        sign_b_d = req_sign_b;
                        op_d     = ReqOp;
                        state_d  = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Sample in the cycle whose decrement reaches zero: LATENCY cycles after MulStart.
                if (Flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    sample      = 1'b1;
                    cnt_d       = '0;
                    resp_data_d = fill_data;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (Flush || RespReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign MulStart  = (state_q == ST_LAUNCH);
    assign MulA      = a_q;
    assign MulB      = b_q;
    assign MulSignA  = sign_a_q;
    assign MulSignB  = sign_b_q;
    assign RespValid = (state_q == ST_DONE);
    assign RespData  = resp_data_q;
    assign RespRd    = rd_q;
    assign Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: transaction-level model with a modelled multiplier array.
module tb_mul_seq_ctrl;

    localparam int LAT = 4;
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    logic         Clk        = 1'b0;
    logic         Rst        = 1'b0;
    logic         ReqValid   = 1'b0;
    logic         ReqReady;
    logic [2:0]   ReqOp      = '0;
    logic [63:0]  ReqRs1     = '0;
    logic [63:0]  ReqRs2     = '0;
    logic [4:0]   ReqRd      = '0;
    logic         Flush      = 1'b0;
    logic         MulStart;
    logic [63:0]  MulA;
    logic [63:0]  MulB;
    logic         MulSignA;
    logic         MulSignB;
    logic [127:0] MulProduct = '0;
    logic         RespValid;
    logic         RespReady  = 1'b0;
    logic [63:0]  RespData;
    logic [4:0]   RespRd;
    logic         Busy;

    always #5 Clk = ~Clk;

    mul_seq_ctrl #(
        .LATENCY (LAT),
        .XLEN    (64)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqOp      (ReqOp),
        .ReqRs1     (ReqRs1),
        .ReqRs2     (ReqRs2),
        .ReqRd      (ReqRd),
        .Flush      (Flush),
        .MulStart   (MulStart),
        .MulA       (MulA),
        .MulB       (MulB),
        .MulSignA   (MulSignA),
        .MulSignB   (MulSignB),
        .MulProduct (MulProduct),
        .RespValid  (RespValid),
        .RespReady  (RespReady),
        .RespData   (RespData),
        .RespRd     (RespRd),
        .Busy       (Busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_starts = 0;

    // model of the controller's visible behaviour, in cycle numbers
    bit           m_known = 0;
    bit           m_busy = 0, m_rv = 0, m_inflight = 0, m_start = 0;
    logic [63:0]  m_data = '0, m_a = '0, m_b = '0;
    logic [4:0]   m_rd = '0;
    logic [2:0]   m_op = '0;
    bit           m_sa = 0, m_sb = 0;
    int           m_start_cyc = 0, m_sample_cyc = 0;
    bit           c_v = 0, c_sa = 0, c_sb = 0;
    logic [63:0]  c_a = '0, c_b = '0;
    logic [127:0] c_p = '0;

    logic [127:0] arr_p[$];
    int           arr_due[$];

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input bit sa, input bit sb);
        logic [127:0] ea, eb;
        ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] pick(input logic [2:0] op, input logic [127:0] p);
        if (op == OP_MUL) return p[63:0];
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[127:64];
        if (op == OP_MULW) return sx32(p[31:0]);
        return 64'd0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d actual=no-event required=event", name, cyc);
    endtask

    task automatic compare_and_step();
        logic [127:0] p;
        bit hit, sa, sb;
        if (m_known) begin
            chk("ReqReady", 128'(ReqReady), 128'(!m_busy && !Flush));
            chk("Busy", 128'(Busy), 128'(m_busy));
            chk("RespValid", 128'(RespValid), 128'(m_rv));
            chk("MulStart", 128'(MulStart), 128'(m_start));
            if (m_rv) begin
                chk("RespData", 128'(RespData), 128'(m_data));
                chk("RespRd", 128'(RespRd), 128'(m_rd));
            end
            if (m_start) begin
                chk("MulA", 128'(MulA), 128'(m_a));
                chk("MulB", 128'(MulB), 128'(m_b));
                chk("MulSignA", 128'(MulSignA), 128'(m_sa));
                chk("MulSignB", 128'(MulSignB), 128'(m_sb));
            end
        end
        if (MulStart === 1'b1) begin
            n_starts++;
            arr_p.push_back(ref_mul(MulA, MulB, MulSignA, MulSignB));
            arr_due.push_back(cyc + LAT);
        end
        if (!Rst) begin
            m_known = 1; m_busy = 0; m_rv = 0; m_inflight = 0; c_v = 0;
        end else if (m_rv) begin
            if (Flush || RespReady) begin m_rv = 0; m_busy = 0; end
        end else if (m_inflight) begin
            if (Flush) begin
                m_inflight = 0; m_busy = 0;
            end else if (cyc == m_sample_cyc) begin
                p = ref_mul(m_a, m_b, m_sa, m_sb);
                m_data = pick(m_op, p);
                m_rv = 1;
                m_inflight = 0;
                if (m_op != OP_MULW) begin
                    c_v = 1; c_a = m_a; c_b = m_b; c_sa = m_sa; c_sb = m_sb; c_p = p;
                end
            end
        end else if (ReqValid && !Flush) begin
            m_busy = 1;
            m_rd = ReqRd;
            if (ReqOp > OP_MULW) begin
                m_data = '0; m_rv = 1;
            end else begin
                sa = (ReqOp != OP_MULHU);
                sb = (ReqOp == OP_MUL) || (ReqOp == OP_MULH) || (ReqOp == OP_MULW);
                hit = c_v && (ReqOp != OP_MULW) && (ReqRs1 == c_a) && (ReqRs2 == c_b) &&
                      ((ReqOp == OP_MUL) || (sa == c_sa && sb == c_sb));
                if (hit) begin
                    m_data = pick(ReqOp, c_p); m_rv = 1;
                end else begin
                    m_inflight = 1; m_op = ReqOp; m_sa = sa; m_sb = sb;
                    m_a = (ReqOp == OP_MULW) ? sx32(ReqRs1[31:0]) : ReqRs1;
                    m_b = (ReqOp == OP_MULW) ? sx32(ReqRs2[31:0]) : ReqRs2;
                    m_start_cyc = cyc + 1;
                    m_sample_cyc = cyc + 1 + LAT;
                end
            end
        end
        m_start = m_inflight && (cyc + 1 == m_start_cyc);
    endtask

    task automatic drive_product();
        while (arr_due.size() > 0 && arr_due[0] < cyc) begin
            void'(arr_due.pop_front());
            void'(arr_p.pop_front());
        end
        if (arr_due.size() > 0 && arr_due[0] == cyc) MulProduct = arr_p[0];
        else MulProduct = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic tick();
        @(negedge Clk);
        compare_and_step();
        @(posedge Clk);
        #1;
        cyc++;
        drive_product();
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, output int acc);
        ReqValid = 1; ReqOp = op; ReqRs1 = a; ReqRs2 = b; ReqRd = rd;
        acc = -1;
        for (int i = 0; i < 40 && acc < 0; i++) begin
            #1;
            if (ReqReady === 1'b1) acc = cyc;
            tick();
        end
        ReqValid = 0;
        if (acc < 0) timeout_fail("accept_timeout");
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int i = 0; i < 40 && rc < 0; i++) begin
            #1;
            if (RespValid === 1'b1) rc = cyc;
            else tick();
        end
        if (rc < 0) timeout_fail("resp_timeout");
    endtask

    task automatic consume();
        RespReady = 1;
        tick();
        RespReady = 0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp_data,
                          input int exp_lat, input int exp_starts);
        int acc, rc, s0;
        s0 = n_starts;
        issue(op, a, b, rd, acc);
        wait_resp(rc);
        chk({name, "_lat"}, 128'(rc - acc), 128'(exp_lat));
        chk({name, "_data"}, 128'(RespData), 128'(exp_data));
        chk({name, "_rd"}, 128'(RespRd), 128'(rd));
        chk({name, "_starts"}, 128'(n_starts - s0), 128'(exp_starts));
        consume();
    endtask

    localparam logic [63:0] M3 = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] XV = 64'hDEAD_BEEF_0000_0001;

    initial begin
        int acc, rc, s0;
        logic [63:0] pool [3];
        pool[0] = M3; pool[1] = 64'd5; pool[2] = 64'h8000_0000_0000_0000;

        // reset for two cycles with a noisy product bus
        Rst = 0;
        @(posedge Clk); #1;
        drive_product();
        tick();
        #1;
        chk("rst_RespValid", 128'(RespValid), 128'(0));
        chk("rst_ReqReady", 128'(ReqReady), 128'(1));
        chk("rst_MulStart", 128'(MulStart), 128'(0));
        chk("rst_Busy", 128'(Busy), 128'(0));
        chk("rst_MulA", 128'(MulA), 128'(0));
        chk("rst_MulB", 128'(MulB), 128'(0));
        chk("rst_signs", 128'({MulSignA, MulSignB}), 128'(0));
        chk("rst_RespData", 128'(RespData), 128'(0));
        chk("rst_RespRd", 128'(RespRd), 128'(0));
        tick();
        Rst = 1;
        tick();

        run_op("mulhu_max", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'd1, 2 + LAT, 1);
        run_op("mulh_m3_5", OP_MULH, M3, 64'd5, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 2 + LAT, 1);
        run_op("mul_hit", OP_MUL, M3, 64'd5, 5'd4, 64'hFFFF_FFFF_FFFF_FFF1, 1, 0);
        run_op("mulhu_sign_miss", OP_MULHU, M3, 64'd5, 5'd9, 64'd4, 2 + LAT, 1);
        run_op("mulw_zero", OP_MULW, 64'h0000_0001_8000_0000, 64'd2, 5'd10, 64'd0, 2 + LAT, 1);
        run_op("mulw_neg", OP_MULW, 64'h4000_0000, 64'd2, 5'd11, 64'hFFFF_FFFF_8000_0000, 2 + LAT, 1);

        // flush two cycles into WAIT
        issue(OP_MUL, XV, 64'h100, 5'd12, acc);
        tick(); tick();
        Flush = 1;
        tick();
        Flush = 0;
        #1;
        chk("flush_busy", 128'(Busy), 128'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("flush_no_resp", 128'(RespValid), 128'(0));
        end
        run_op("mul_hit_after_flush", OP_MUL, M3, 64'd5, 5'd13, 64'hFFFF_FFFF_FFFF_FFF1, 1, 0);

        // DONE hold, then flush together with RespReady
        s0 = n_starts;
        issue(OP_MULHU, XV, 64'h100, 5'd14, acc);
        wait_resp(rc);
        chk("hold_lat", 128'(rc - acc), 128'(2 + LAT));
        chk("hold_starts", 128'(n_starts - s0), 128'(1));
        ReqValid = 1; ReqOp = OP_MUL; ReqRs1 = 64'd1; ReqRs2 = 64'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("hold_data", 128'(RespData), 128'(64'hDE));
            chk("hold_rd", 128'(RespRd), 128'(14));
            chk("hold_ready", 128'(ReqReady), 128'(0));
        end
        ReqValid = 0;
        RespReady = 1; Flush = 1;
        tick();
        RespReady = 0; Flush = 0;
        #1;
        chk("flushwin_valid", 128'(RespValid), 128'(0));
        chk("flushwin_busy", 128'(Busy), 128'(0));

        run_op("reserved", 3'd6, XV, 64'd3, 5'd15, 64'd0, 1, 0);

        // reset in WAIT discards the operation and empties the cache
        issue(OP_MULH, 64'd7, 64'd9, 5'd16, acc);
        tick();
        Rst = 0;
        tick();
        Rst = 1;
        for (int i = 0; i < 8; i++) tick();
        #1;
        chk("rstmid_valid", 128'(RespValid), 128'(0));
        run_op("mul_after_reset", OP_MUL, M3, 64'd5, 5'd17, 64'hFFFF_FFFF_FFFF_FFF1, 2 + LAT, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Rst       = ($urandom_range(0, 299) != 0);
            Flush     = ($urandom_range(0, 15) == 0);
            RespReady = 1'($urandom_range(0, 1));
            ReqValid  = 1'($urandom_range(0, 1));
            ReqOp     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                                     : 3'($urandom_range(0, 4));
            ReqRs1    = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 2)] : {$urandom, $urandom};
            ReqRs2    = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 2)] : {$urandom, $urandom};
            ReqRd     = 5'($urandom_range(0, 31));
            tick();
        end
        Rst = 1; Flush = 0; ReqValid = 0; RespReady = 1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
